pe_mac_8bit: RTL and testbench

Output-stationary processing element for the 8-bit systolic array. Each cycle it forwards operand A east and operand B south through one register stage. When both operands are valid it multiplies them with one `Wallace_8bit` instance and accumulates the product into a saturating accumulator. On a drain request it hands the tile result to a one-entry output buffer with a valid/ready handshake, so accumulation of the next tile never stalls the array.

---
 rtl/pe_mac_8bit.sv | 188 ++++++++++++++++++
 tb/tb_pe_mac_8bit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_8bit.sv
// Output-stationary systolic-array PE: forwards A east and B south, multiplies
// with a carry-save Wallace_8bit, saturating accumulate, one-entry result buffer.

module Wallace_8bit #(
    parameter int APPROX = 0
) (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] prod_o
);
    // Columns below APPROX are dropped from every partial product.
    localparam logic [15:0] COL_MASK = 16'hFFFF << APPROX;

    // 3:2 compressor on whole rows; returns {sum, carry shifted into place}.
    function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
        logic [15:0] s;
        logic [15:0] m;
        s = x ^ y ^ z;
        m = (x & y) | (x & z) | (y & z);
        return {s, m[14:0], 1'b0};
    endfunction

    logic [15:0] pp_s [8];
    logic [15:0] s0_s, c0_s, s1_s, c1_s, s2_s, c2_s, s3_s, c3_s, s4_s, c4_s, s5_s, c5_s;

    for (genvar i = 0; i < 8; i++) begin : g_pp
        assign pp_s[i] = ({8'd0, a_i & {8{b_i[i]}}} << i) & COL_MASK;
    end

    assign {s0_s, c0_s} = csa(pp_s[0], pp_s[1], pp_s[2]);
    assign {s1_s, c1_s} = csa(pp_s[3], pp_s[4], pp_s[5]);
    assign {s2_s, c2_s} = csa(s0_s, c0_s, s1_s);
    assign {s3_s, c3_s} = csa(c1_s, pp_s[6], pp_s[7]);
    assign {s4_s, c4_s} = csa(s2_s, c2_s, s3_s);
    assign {s5_s, c5_s} = csa(s4_s, c4_s, c3_s);
    assign prod_o       = s5_s + c5_s;
endmodule

module pe_mac_8bit #(
    parameter int APPROX = 0,
    parameter int ACC_W  = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       a_in,
    input  logic             a_vin,
    input  logic [7:0]       b_in,
    input  logic             b_vin,
    input  logic             acc_clr,
    input  logic             drain,
    input  logic             res_ready,
    output logic [7:0]       a_out,
    output logic             a_vout,
    output logic [7:0]       b_out,
    output logic             b_vout,
    output logic [ACC_W-1:0] res_data,
    output logic [7:0]       res_cnt,
    output logic             res_sat,
    output logic             res_valid,
    output logic             ovf_err
);
    typedef enum logic {BUF_EMPTY = 1'b0, BUF_FULL = 1'b1} buf_state_e;

    logic [7:0]       a_q, b_q;
    logic             av_q, bv_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [ACC_W-1:0] rdata_q, rdata_d;
    logic [7:0]       rcnt_q, rcnt_d;
    logic             rsat_q, rsat_d;
    buf_state_e       state_q, state_d;
    logic             ovf_q, ovf_d;

    logic             mac_s;
    logic [15:0]      prod_s;
    logic [ACC_W:0]   sum_s;
    logic [ACC_W-1:0] acc_next_s;
    logic [7:0]       cnt_next_s;
    logic             sat_next_s;
    logic             drain_ok_s;

    Wallace_8bit #(.APPROX(APPROX)) u_mul (
        .a_i    (a_in),
        .b_i    (b_in),
        .prod_o (prod_s)
    );

    assign mac_s      = a_vin & b_vin;
    assign sum_s      = {1'b0, acc_q} + (ACC_W + 1)'(prod_s);
    assign drain_ok_s = drain & ((state_q == BUF_EMPTY) | res_ready);

    // Value the tile would hold after this cycle's MAC, with saturation folded in.
    always_comb begin
        acc_next_s = acc_q;
        cnt_next_s = cnt_q;
        sat_next_s = sat_q;
        if (mac_s) begin
            acc_next_s = sum_s[ACC_W] ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];
            cnt_next_s = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            sat_next_s = sat_q | sum_s[ACC_W];
        end else begin
            acc_next_s = acc_q;
        end
    end

    // Accumulator priority (accepted drain > clear > MAC) and result buffer control.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        rdata_d = rdata_q;
        rcnt_d  = rcnt_q;
        rsat_d  = rsat_q;
        state_d = state_q;
        ovf_d   = drain & (state_q == BUF_FULL) & ~res_ready;

        if (drain_ok_s) begin
            rdata_d = acc_next_s;
            rcnt_d  = cnt_next_s;
            rsat_d  = sat_next_s;
            state_d = BUF_FULL;
            acc_d   = {ACC_W{1'b0}};
            cnt_d   = 8'd0;
            sat_d   = 1'b0;
        end else begin
            // A rejected drain leaves the tile alive, so clear/MAC still apply.
            if (acc_clr) begin
                acc_d = mac_s ? ACC_W'(prod_s) : {ACC_W{1'b0}};
                cnt_d = {7'd0, mac_s};
                sat_d = 1'b0;
            end else if (mac_s) begin
                acc_d = acc_next_s;
                cnt_d = cnt_next_s;
                sat_d = sat_next_s;
            end else begin
                acc_d = acc_q;
            end
            if ((state_q == BUF_FULL) && res_ready) begin
                state_d = BUF_EMPTY;
            end else begin
                state_d = state_q;
            end
        end
    end

    // All state, including the forwarding pipeline, in one register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= 8'd0;
            av_q    <= 1'b0;
            b_q     <= 8'd0;
            bv_q    <= 1'b0;
            acc_q   <= {ACC_W{1'b0}};
            cnt_q   <= 8'd0;
            sat_q   <= 1'b0;
            rdata_q <= {ACC_W{1'b0}};
            rcnt_q  <= 8'd0;
            rsat_q  <= 1'b0;
            state_q <= BUF_EMPTY;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_in;
            av_q    <= a_vin;
            b_q     <= b_in;
            bv_q    <= b_vin;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            rdata_q <= rdata_d;
            rcnt_q  <= rcnt_d;
            rsat_q  <= rsat_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    assign a_out     = a_q;
    assign a_vout    = av_q;
    assign b_out     = b_q;
    assign b_vout    = bv_q;
    assign res_data  = rdata_q;
    assign res_cnt   = rcnt_q;
    assign res_sat   = rsat_q;
    assign res_valid = (state_q == BUF_FULL);
    assign ovf_err   = ovf_q;
endmodule

// File: tb/tb_pe_mac_8bit.sv
// Directed bench for pe_mac_8bit: a 24-bit and a 16-bit instance share stimulus.

module tb_pe_mac_8bit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  a_in, b_in;
    logic        a_vin, b_vin, acc_clr, drain, res_ready;
    logic [7:0]  a_out, b_out, a_out16, b_out16;
    logic        a_vout, b_vout, a_vout16, b_vout16;
    logic [23:0] res_data;
    logic [15:0] res_data16;
    logic [7:0]  res_cnt, res_cnt16;
    logic        res_sat, res_valid, ovf_err, res_sat16, res_valid16, ovf_err16;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    pe_mac_8bit #(.APPROX(0), .ACC_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .a_vin(a_vin), .b_in(b_in), .b_vin(b_vin),
        .acc_clr(acc_clr), .drain(drain), .res_ready(res_ready),
        .a_out(a_out), .a_vout(a_vout), .b_out(b_out), .b_vout(b_vout),
        .res_data(res_data), .res_cnt(res_cnt), .res_sat(res_sat),
        .res_valid(res_valid), .ovf_err(ovf_err));

    pe_mac_8bit #(.APPROX(0), .ACC_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .a_vin(a_vin), .b_in(b_in), .b_vin(b_vin),
        .acc_clr(acc_clr), .drain(drain), .res_ready(res_ready),
        .a_out(a_out16), .a_vout(a_vout16), .b_out(b_out16), .b_vout(b_vout16),
        .res_data(res_data16), .res_cnt(res_cnt16), .res_sat(res_sat16),
        .res_valid(res_valid16), .ovf_err(ovf_err16));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic av, input logic [7:0] b,
                         input logic bv, input logic clr, input logic drn, input logic rdy);
        a_in = a; a_vin = av; b_in = b; b_vin = bv;
        acc_clr = clr; drain = drn; res_ready = rdy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        drive(8'd2, 1'b1, 8'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(8'd20, 1'b1, 8'd233, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        n_total++;
        if (res_valid !== 1'b1 || a_out !== 8'd20)
            $display("FAIL reset_pre: valid=%b a_out=%0d required 1/20", res_valid, a_out);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({a_out, a_vout, b_out, b_vout} !== 18'd0)
            $display("FAIL reset_fwd: got %h required 0", {a_out, a_vout, b_out, b_vout});
        else n_pass++;
        n_total++;
        if ({res_data, res_cnt, res_sat, res_valid, ovf_err} !== 35'd0)
            $display("FAIL reset_res: got %h required 0",
                     {res_data, res_cnt, res_sat, res_valid, ovf_err});
        else n_pass++;
        drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        drive(8'd2, 1'b1, 8'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        n_total++;
        if (res_data !== 24'd6 || res_cnt !== 8'd1 || res_valid !== 1'b1)
            $display("FAIL reset_first_mac: data=%0d cnt=%0d valid=%b required 6/1/1",
                     res_data, res_cnt, res_valid);
        else n_pass++;
    endtask

    task automatic test_forwarding();
        drive(8'h12, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        n_total++;
        if (a_out !== 8'h12 || a_vout !== 1'b1)
            $display("FAIL fwd_a: a_out=%h a_vout=%b required 12/1", a_out, a_vout);
        else n_pass++;
        n_total++;
        if (b_out !== 8'h55 || b_vout !== 1'b0)
            $display("FAIL fwd_b: b_out=%h b_vout=%b required 55/0", b_out, b_vout);
        else n_pass++;
        drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        n_total++;
        if (res_data !== 24'd0 || res_cnt !== 8'd0)
            $display("FAIL fwd_acc_unchanged: data=%0d cnt=%0d required 0/0", res_data, res_cnt);
        else n_pass++;
    endtask

    task automatic test_accumulate_drain();
        drive(8'd3, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(8'd5, 1'b1, 8'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(8'd255, 1'b1, 8'd255, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        n_total++;
        if (res_data !== 24'd65067 || res_cnt !== 8'd3 || res_sat !== 1'b0 || res_valid !== 1'b1)
            $display("FAIL acc_drain: data=%0d cnt=%0d sat=%b valid=%b required 65067/3/0/1",
                     res_data, res_cnt, res_sat, res_valid);
        else n_pass++;
        drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        n_total++;
        if (res_valid !== 1'b0)
            $display("FAIL acc_valid_one_cycle: valid=%b required 0", res_valid);
        else n_pass++;
        drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        n_total++;
        if (res_data !== 24'd0 || res_cnt !== 8'd0 || res_valid !== 1'b1)
            $display("FAIL acc_zero_after: data=%0d cnt=%0d valid=%b required 0/0/1",
                     res_data, res_cnt, res_valid);
        else n_pass++;
        drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_back_pressure();
        drive(8'd3, 1'b1, 8'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(8'd7, 1'b1, 8'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        n_total++;
        if (ovf_err !== 1'b1 || res_data !== 24'd12 || res_valid !== 1'b1)
            $display("FAIL bp_reject: ovf=%b data=%0d valid=%b required 1/12/1",
                     ovf_err, res_data, res_valid);
        else n_pass++;
        drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        n_total++;
        if (ovf_err !== 1'b0 || res_data !== 24'd12 || res_cnt !== 8'd1)
            $display("FAIL bp_hold: ovf=%b data=%0d cnt=%0d required 0/12/1",
                     ovf_err, res_data, res_cnt);
        else n_pass++;
        drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        n_total++;
        if (res_data !== 24'd98 || res_cnt !== 8'd2 || res_valid !== 1'b1 || ovf_err !== 1'b0)
            $display("FAIL bp_swap: data=%0d cnt=%0d valid=%b ovf=%b required 98/2/1/0",
                     res_data, res_cnt, res_valid, ovf_err);
        else n_pass++;
        drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_saturation();
        drive(8'd255, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (2) tick();
        drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        n_total++;
        if (res_data16 !== 16'hFFFF || res_sat16 !== 1'b1 || res_cnt16 !== 8'd2)
            $display("FAIL sat16: data=%h sat=%b cnt=%0d required ffff/1/2",
                     res_data16, res_sat16, res_cnt16);
        else n_pass++;
        n_total++;
        if (res_data !== 24'd130050 || res_sat !== 1'b0)
            $display("FAIL sat24_exact: data=%0d sat=%b required 130050/0", res_data, res_sat);
        else n_pass++;
        drive(8'd1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        n_total++;
        if (res_data16 !== 16'd1 || res_sat16 !== 1'b0 || res_cnt16 !== 8'd1)
            $display("FAIL sat16_next_tile: data=%0d sat=%b cnt=%0d required 1/0/1",
                     res_data16, res_sat16, res_cnt16);
        else n_pass++;
    endtask

    task automatic test_clear_with_mac();
        drive(8'd20, 1'b1, 8'd25, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(8'd10, 1'b1, 8'd10, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        n_total++;
        if (res_data !== 24'd100 || res_cnt !== 8'd1)
            $display("FAIL clr_mac: data=%0d cnt=%0d required 100/1", res_data, res_cnt);
        else n_pass++;
    endtask

    task automatic test_cnt_saturation();
        drive(8'd1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (300) tick();
        drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        n_total++;
        if (res_data !== 24'd300 || res_cnt !== 8'd255 || res_sat !== 1'b0)
            $display("FAIL cnt_sat: data=%0d cnt=%0d sat=%b required 300/255/0",
                     res_data, res_cnt, res_sat);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_accumulate_drain();
        test_back_pressure();
        test_saturation();
        test_clear_with_mac();
        test_cnt_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
